// File: rtl/renkon_maxpool_pkg.sv
// Shared constants, row-phase enum and the signed-max helper for the renkon max-pooling stage.
package renkon_maxpool_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int MAXW_DEF   = 32;
    localparam int LWIDTH_DEF = 6;

    typedef logic signed [DWIDTH_DEF-1:0] pixel_t;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } rowPhase_t;

    // Ties return the first operand, so the earlier pixel wins.
    function automatic pixel_t signedMax(input pixel_t a, input pixel_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/renkon_maxpool_linebuf.sv
// Half-width line buffer holding the pairwise maxima of the last even row.
module renkon_maxpool_linebuf #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     wrEn_i,
    input  logic [AWIDTH-1:0]        wrAddr_i,
    input  logic signed [DWIDTH-1:0] wrData_i,
    input  logic [AWIDTH-1:0]        rdAddr_i,
    output logic signed [DWIDTH-1:0] rdData_o
);

    logic signed [DWIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/renkon_maxpool.sv
// 2x2 stride-2 max-pooling over a raster pixel stream; one pooled pixel per window.
module renkon_maxpool
    import renkon_maxpool_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int MAXW   = MAXW_DEF,
    parameter int LWIDTH = LWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     init,
    input  logic [LWIDTH-1:0]        img_w,
    input  logic                     in_en,
    input  logic signed [DWIDTH-1:0] pixel_in,
    output logic                     out_en,
    output logic signed [DWIDTH-1:0] pixel_out
);

    localparam int DEPTH  = MAXW / 2;
    localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LWIDTH-1:0]        width_q;
    logic [LWIDTH-1:0]        col_q;
    rowPhase_t                rowPhase_q;
    logic signed [DWIDTH-1:0] hold_q;
    logic                     outEn_q;
    logic signed [DWIDTH-1:0] pixelOut_q;

    logic [LWIDTH-1:0]        widthEff;
    logic                     lastCol;
    logic                     colOdd;
    logic [LWIDTH-1:0]        halfCol;
    logic [AWIDTH-1:0]        bufAddr;
    logic                     bufWrEn;
    logic signed [DWIDTH-1:0] bufRdData;
    logic signed [DWIDTH-1:0] hmax;
    logic signed [DWIDTH-1:0] vmax;

    // A programmed width of zero selects the full maximum width.
    always_comb begin
        widthEff = (width_q == '0) ? LWIDTH'(MAXW) : width_q;
        lastCol  = (col_q == widthEff - LWIDTH'(1));
        colOdd   = col_q[0];
        halfCol  = col_q >> 1;
        bufAddr  = halfCol[AWIDTH-1:0];
        hmax     = signedMax(hold_q, pixel_in);
        vmax     = signedMax(bufRdData, hmax);
        bufWrEn  = in_en && !init && colOdd && (rowPhase_q == ROW_EVEN);
    end

    renkon_maxpool_linebuf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_linebuf (
        .clk      (clk),
        .wrEn_i   (bufWrEn),
        .wrAddr_i (bufAddr),
        .wrData_i (hmax),
        .rdAddr_i (bufAddr),
        .rdData_o (bufRdData)
    );

    // Position state moves only on accepted pixels; init wins over a same-cycle pixel.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            width_q    <= '0;
            col_q      <= '0;
            rowPhase_q <= ROW_EVEN;
            hold_q     <= '0;
            outEn_q    <= 1'b0;
            pixelOut_q <= '0;
        end else if (init) begin
            width_q    <= img_w;
            col_q      <= '0;
            rowPhase_q <= ROW_EVEN;
            hold_q     <= '0;
            outEn_q    <= 1'b0;
        end else begin
            outEn_q <= 1'b0;
            if (in_en) begin
                if (!colOdd) begin
                    hold_q <= pixel_in;
                end
                if (lastCol) begin
                    col_q      <= '0;
                    rowPhase_q <= (rowPhase_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    col_q <= col_q + LWIDTH'(1);
                end
                if (colOdd && (rowPhase_q == ROW_ODD)) begin
                    outEn_q    <= 1'b1;
                    pixelOut_q <= vmax;
                end
            end
        end
    end

    assign out_en    = outEn_q;
    assign pixel_out = pixelOut_q;

endmodule
